// File: rtl/line_scan_controller.sv
// line_scan_controller: steps through a range of lines held in a line_buffer
// and streams each line's pixels out on a valid/ready port.
// Ports: CLK, RESET_N (async, active-low).
//   Control: START, ABORT, FIRST_LINE, LAST_LINE, LINE_STEP.
//   Status: BUSY, DONE, CONFIG_ERROR.
//   Buffer side: INTERESTING_LINE, WHOLE_LINE_READY_FLAG, READ_ADDRESS,
//     BUFFER_DATA, RESET_READY_FLAG.
//   Stream side: OUT_DATA, OUT_LINE, OUT_COLUMN, OUT_LAST, OUT_VALID,
//     OUT_READY.
module line_scan_controller #(
    parameter int LINES        = 3,
    parameter int COLUMNS      = 2,
    parameter int LINE_BITS    = 2,
    parameter int COLUMN_BITS  = 1,
    parameter int DATA_BITS    = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic [LINE_BITS-1:0]   FIRST_LINE,
    input  logic [LINE_BITS-1:0]   LAST_LINE,
    input  logic [LINE_BITS-1:0]   LINE_STEP,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   CONFIG_ERROR,
    output logic [LINE_BITS-1:0]   INTERESTING_LINE,
    input  logic                   WHOLE_LINE_READY_FLAG,
    output logic [COLUMN_BITS-1:0] READ_ADDRESS,
    input  logic [DATA_BITS-1:0]   BUFFER_DATA,
    output logic                   RESET_READY_FLAG,
    output logic [DATA_BITS-1:0]   OUT_DATA,
    output logic [LINE_BITS-1:0]   OUT_LINE,
    output logic [COLUMN_BITS-1:0] OUT_COLUMN,
    output logic                   OUT_LAST,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY
);

    localparam logic [LINE_BITS:0]     LINES_W = (LINE_BITS+1)'(LINES);
    localparam logic [COLUMN_BITS-1:0] COL_MAX = COLUMN_BITS'(COLUMNS-1);
    localparam logic [1:0]             LAT     = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_PRESENT,
        S_RELEASE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LINE_BITS-1:0]   line_q;
    logic [LINE_BITS-1:0]   last_q;
    logic [LINE_BITS-1:0]   step_q;
    logic [COLUMN_BITS-1:0] col_q;
    logic [1:0]             lat_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [LINE_BITS-1:0]   oline_q;
    logic [COLUMN_BITS-1:0] ocol_q;
    logic                   olast_q;
    logic                   abort_rel_q;
    logic                   cfg_err_q;

    logic                   range_ok;
    logic                   col_last;
    logic                   lat_done;
    logic                   next_out;
    logic                   abort_hit;
    logic [LINE_BITS:0]     step_eff;
    logic [LINE_BITS:0]     next_line;

    assign range_ok  = (FIRST_LINE <= LAST_LINE) &&
                       ({1'b0, LAST_LINE} < LINES_W);
    assign col_last  = (col_q == COL_MAX);
    assign lat_done  = (lat_q == LAT);
    assign abort_hit = ABORT && (state_q != S_IDLE);

    // Zero stride would never advance, so it behaves as a stride of one.
    // The extra bit keeps the sum from wrapping back into the range.
    assign step_eff  = (step_q == '0) ? (LINE_BITS+1)'(1)
                                      : {1'b0, step_q};
    assign next_line = {1'b0, line_q} + step_eff;
    assign next_out  = (next_line > {1'b0, last_q}) ||
                       (next_line >= LINES_W);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START && !ABORT && range_ok) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (WHOLE_LINE_READY_FLAG) state_d = S_READ;
                end
                S_READ: begin
                    if (lat_done) state_d = S_PRESENT;
                end
                S_PRESENT: begin
                    if (OUT_READY) state_d = col_last ? S_RELEASE : S_READ;
                end
                S_RELEASE: state_d = S_NEXT;
                S_NEXT:    state_d = next_out ? S_FINISH : S_WAIT;
                S_FINISH:  state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            line_q      <= '0;
            last_q      <= '0;
            step_q      <= '0;
            col_q       <= '0;
            lat_q       <= '0;
            data_q      <= '0;
            oline_q     <= '0;
            ocol_q      <= '0;
            olast_q     <= 1'b0;
            abort_rel_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q   <= 1'b0;
            abort_rel_q <= 1'b0;
            if (abort_hit) begin
                // Hand the buffer back so it can capture a fresh line.
                abort_rel_q <= 1'b1;
                col_q       <= '0;
                lat_q       <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            if (range_ok) begin
                                line_q <= FIRST_LINE;
                                last_q <= LAST_LINE;
                                step_q <= LINE_STEP;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (WHOLE_LINE_READY_FLAG) begin
                            col_q <= '0;
                            lat_q <= '0;
                        end
                    end
                    S_READ: begin
                        if (lat_done) begin
                            data_q  <= BUFFER_DATA;
                            oline_q <= line_q;
                            ocol_q  <= col_q;
                            olast_q <= col_last;
                        end else begin
                            lat_q <= lat_q + 2'd1;
                        end
                    end
                    S_PRESENT: begin
                        if (OUT_READY && !col_last) begin
                            col_q <= col_q + COLUMN_BITS'(1);
                            lat_q <= '0;
                        end
                    end
                    S_NEXT: begin
                        if (!next_out) line_q <= next_line[LINE_BITS-1:0];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign BUSY             = (state_q != S_IDLE);
    assign DONE             = (state_q == S_FINISH);
    assign CONFIG_ERROR     = cfg_err_q;
    assign INTERESTING_LINE = line_q;
    assign READ_ADDRESS     = (state_q == S_READ || state_q == S_PRESENT)
                              ? col_q : '0;
    assign RESET_READY_FLAG = (state_q == S_RELEASE) || abort_rel_q;
    assign OUT_DATA         = data_q;
    assign OUT_LINE         = oline_q;
    assign OUT_COLUMN       = ocol_q;
    assign OUT_LAST         = olast_q;
    assign OUT_VALID        = (state_q == S_PRESENT);

endmodule

// File: tb/tb_line_scan_controller.sv
// tb_line_scan_controller: directed bench for line_scan_controller with a
// behavioural line_buffer per instance (latencies 0, 1 and 2).
module tb_line_scan_controller;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [1:0] FIRST_LINE = '0;
    logic [1:0] LAST_LINE = '0;
    logic [1:0] LINE_STEP = '0;
    logic       flag = 1'b0;
    logic       ready_base = 1'b0;
    logic       stall_on = 1'b0;
    int         stall_cnt = 0;
    int         cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [9:0] pix(input logic [1:0] l, input logic c);
        return 10'(int'(l) * 10 + 10 + int'(c) + 1);
    endfunction

    // main instance, READ_LATENCY = 1
    logic       busy, done, cerr, rrf, valid, last, ready, stall;
    logic [1:0] il, oline;
    logic       ra, ocol;
    logic [9:0] bd, odata;

    assign stall = stall_on && valid && oline == 2'd1 && ocol == 1'b0 &&
                   stall_cnt < 5;
    assign ready = ready_base && !stall;

    always @(posedge CLK) begin
        if (!stall_on) stall_cnt <= 0;
        else if (stall) stall_cnt <= stall_cnt + 1;
        bd <= pix(il, ra);
    end

    line_scan_controller #(.READ_LATENCY(1)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .FIRST_LINE(FIRST_LINE), .LAST_LINE(LAST_LINE),
        .LINE_STEP(LINE_STEP), .BUSY(busy), .DONE(done),
        .CONFIG_ERROR(cerr), .INTERESTING_LINE(il),
        .WHOLE_LINE_READY_FLAG(flag), .READ_ADDRESS(ra),
        .BUFFER_DATA(bd), .RESET_READY_FLAG(rrf), .OUT_DATA(odata),
        .OUT_LINE(oline), .OUT_COLUMN(ocol), .OUT_LAST(last),
        .OUT_VALID(valid), .OUT_READY(ready)
    );

    // latency 0 instance
    logic       a0_busy, a0_done, a0_cerr, a0_rrf, a0_valid, a0_last;
    logic [1:0] a0_il, a0_oline;
    logic       a0_ra, a0_ocol;
    logic [9:0] a0_bd, a0_odata;
    assign a0_bd = pix(a0_il, a0_ra);

    line_scan_controller #(.READ_LATENCY(0)) u_lat0 (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .FIRST_LINE(FIRST_LINE), .LAST_LINE(LAST_LINE),
        .LINE_STEP(LINE_STEP), .BUSY(a0_busy), .DONE(a0_done),
        .CONFIG_ERROR(a0_cerr), .INTERESTING_LINE(a0_il),
        .WHOLE_LINE_READY_FLAG(flag), .READ_ADDRESS(a0_ra),
        .BUFFER_DATA(a0_bd), .RESET_READY_FLAG(a0_rrf),
        .OUT_DATA(a0_odata), .OUT_LINE(a0_oline), .OUT_COLUMN(a0_ocol),
        .OUT_LAST(a0_last), .OUT_VALID(a0_valid), .OUT_READY(ready_base)
    );

    // latency 2 instance
    logic       a2_busy, a2_done, a2_cerr, a2_rrf, a2_valid, a2_last;
    logic [1:0] a2_il, a2_oline;
    logic       a2_ra, a2_ocol;
    logic [9:0] a2_bd, a2_p1, a2_odata;
    always @(posedge CLK) begin
        a2_p1 <= pix(a2_il, a2_ra);
        a2_bd <= a2_p1;
    end

    line_scan_controller #(.READ_LATENCY(2)) u_lat2 (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .FIRST_LINE(FIRST_LINE), .LAST_LINE(LAST_LINE),
        .LINE_STEP(LINE_STEP), .BUSY(a2_busy), .DONE(a2_done),
        .CONFIG_ERROR(a2_cerr), .INTERESTING_LINE(a2_il),
        .WHOLE_LINE_READY_FLAG(flag), .READ_ADDRESS(a2_ra),
        .BUFFER_DATA(a2_bd), .RESET_READY_FLAG(a2_rrf),
        .OUT_DATA(a2_odata), .OUT_LINE(a2_oline), .OUT_COLUMN(a2_ocol),
        .OUT_LAST(a2_last), .OUT_VALID(a2_valid), .OUT_READY(ready_base)
    );

    // monitor of the main instance, sampled mid-cycle
    logic [13:0] q[$];
    int rel_n = 0, done_n = 0, cerr_n = 0;
    int rel_cyc = 0, done_cyc = 0, h_last = 0;

    always @(negedge CLK) begin
        if (valid && ready) begin
            q.push_back({oline, ocol, last, odata});
            if (last) h_last = cyc + 1;
        end
        if (rrf) begin rel_n++; rel_cyc = cyc; end
        if (done) begin done_n++; done_cyc = cyc; end
        if (cerr) cerr_n++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] px(input int l, input int c,
                                       input int lst, input int d);
        return {2'(l), 1'(c), 1'(lst), 10'(d)};
    endfunction

    task automatic do_start(input logic [1:0] f, input logic [1:0] l,
                            input logic [1:0] s);
        @(posedge CLK); #1;
        FIRST_LINE = f;
        LAST_LINE  = l;
        LINE_STEP  = s;
        START      = 1'b1;
        @(posedge CLK); #1;
        START      = 1'b0;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        @(negedge CLK);
        while (busy && n < max) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic check_seq(input string tag, input int base,
                             input logic [13:0] e[6], input int cnt);
        check({tag, "_count"}, 32'(q.size() - base), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            logic [13:0] g;
            g = (base + i < q.size()) ? q[base + i] : '1;
            check(tag, 32'(g), 32'(e[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rb, db, cb, fe, r0, r1, r2, n;
        logic [13:0] e[6];

        // reset values
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done_cerr", 32'({done, cerr}), 0);
        check("rst_il_ra", 32'({il, ra}), 0);
        check("rst_rrf_valid", 32'({rrf, valid}), 0);
        check("rst_out", 32'({odata, oline, ocol, last}), 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N    = 1'b1;
        flag       = 1'b1;
        ready_base = 1'b1;

        // 1: basic walk 0..2 step 1
        base = q.size(); rb = rel_n; db = done_n;
        do_start(2'd0, 2'd2, 2'd1);
        @(negedge CLK);
        check("t1_busy", 32'(busy), 1);
        run_idle(200);
        e = '{px(0,0,0,11), px(0,1,1,12), px(1,0,0,21),
              px(1,1,1,22), px(2,0,0,31), px(2,1,1,32)};
        check_seq("t1_pix", base, e, 6);
        check("t1_rel", 32'(rel_n - rb), 3);
        check("t1_done", 32'(done_n - db), 1);

        // 2: stride 2
        base = q.size(); rb = rel_n; db = done_n;
        do_start(2'd0, 2'd2, 2'd2);
        run_idle(200);
        e = '{px(0,0,0,11), px(0,1,1,12), px(2,0,0,31),
              px(2,1,1,32), '0, '0};
        check_seq("t2_pix", base, e, 4);
        check("t2_rel", 32'(rel_n - rb), 2);
        check("t2_done", 32'(done_n - db), 1);
        check("t2_rel_at_h", 32'(rel_cyc), 32'(h_last));
        check("t2_done_at_h2", 32'(done_cyc), 32'(h_last + 2));

        // 3: backpressure on pixel 21
        base = q.size();
        stall_on = 1'b1;
        do_start(2'd0, 2'd2, 2'd1);
        n = 0;
        @(negedge CLK);
        while (!stall && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("t3_stall_seen", 32'(stall), 1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_data", 32'(odata), 21);
            check("t3_hold_col_ra", 32'({ocol, ra}), 0);
            check("t3_hold_valid", 32'(valid), 1);
            @(negedge CLK);
        end
        run_idle(200);
        e = '{px(0,0,0,11), px(0,1,1,12), px(1,0,0,21),
              px(1,1,1,22), px(2,0,0,31), px(2,1,1,32)};
        check_seq("t3_pix", base, e, 6);
        @(posedge CLK); #1;
        stall_on = 1'b0;

        // 4: abort while presenting (1,0)
        @(posedge CLK); #1;
        stall_on = 1'b1;
        base = q.size(); rb = rel_n; db = done_n;
        do_start(2'd0, 2'd2, 2'd1);
        n = 0;
        @(negedge CLK);
        while (!stall && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("t4_stall_seen", 32'(stall), 1);
        @(posedge CLK); #1;
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        @(negedge CLK);
        check("t4_valid_drop", 32'(valid), 0);
        check("t4_idle", 32'(busy), 0);
        check("t4_rel_now", 32'(rrf), 1);
        repeat (3) @(negedge CLK);
        check("t4_rel", 32'(rel_n - rb), 2);
        check("t4_no_done", 32'(done_n - db), 0);
        check("t4_pix_count", 32'(q.size() - base), 2);
        @(posedge CLK); #1;
        stall_on = 1'b0;
        base = q.size(); db = done_n;
        do_start(2'd1, 2'd1, 2'd0);
        @(negedge CLK);
        check("t4_restart", 32'({busy, il}), 32'({1'b1, 2'd1}));
        run_idle(200);
        e = '{px(1,0,0,21), px(1,1,1,22), '0, '0, '0, '0};
        check_seq("t4_pix", base, e, 2);
        check("t4_done", 32'(done_n - db), 1);

        // 5: rejected ranges and START with ABORT
        rb = rel_n; cb = cerr_n;
        do_start(2'd2, 2'd1, 2'd1);
        @(negedge CLK);
        check("t5_cerr_a", 32'({cerr, busy}), 32'(2'b10));
        @(negedge CLK);
        check("t5_cerr_pulse", 32'(cerr), 0);
        do_start(2'd2, 2'd3, 2'd1);
        @(negedge CLK);
        check("t5_cerr_b", 32'({cerr, busy}), 32'(2'b10));
        @(posedge CLK); #1;
        FIRST_LINE = 2'd0; LAST_LINE = 2'd2;
        START = 1'b1; ABORT = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; ABORT = 1'b0;
        @(negedge CLK);
        check("t5_abort_wins", 32'({busy, cerr}), 0);
        repeat (2) @(negedge CLK);
        check("t5_cerr_count", 32'(cerr_n - cb), 2);
        check("t5_no_rel", 32'(rel_n - rb), 0);

        // 6: read latency 0/1/2, then async reset in PRESENT
        @(posedge CLK); #1;
        flag = 1'b0; ready_base = 1'b0;
        RESET_N = 1'b0;
        #2;
        RESET_N = 1'b1;
        do_start(2'd0, 2'd0, 2'd1);
        repeat (2) @(posedge CLK);
        #1;
        flag = 1'b1;
        fe = cyc + 1;
        r0 = 0; r1 = 0; r2 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (a0_valid && r0 == 0) r0 = cyc;
            if (valid && r1 == 0) r1 = cyc;
            if (a2_valid && r2 == 0) r2 = cyc;
        end
        check("t6_rise_lat0", 32'(r0), 32'(fe + 1));
        check("t6_rise_lat1", 32'(r1), 32'(fe + 2));
        check("t6_rise_lat2", 32'(r2), 32'(fe + 3));
        check("t6_data_lat2", 32'(a2_odata), 11);
        check("t6_pre_rst", 32'({valid, odata}), 32'({1'b1, 10'd11}));
        rb = rel_n;
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check("t6_rst_valid_busy", 32'({valid, busy, a2_valid}), 0);
        check("t6_rst_out", 32'({odata, oline, ocol, last}), 0);
        check("t6_rst_misc", 32'({il, ra, rrf, done, cerr}), 0);
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("t6_no_rel", 32'(rel_n - rb), 0);
        check("t6_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
